// File: rtl/ustcy_irq_ctrl.sv
// Interrupt controller: synchronizes external sources, latches them as edge or level pending,
// masks them onto core irq lines 16+k and exposes PENDING/ENABLE/TYPE/CLAIM on the data bus.
module ustcy_irq_ctrl #(
  parameter int unsigned N_SRC = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] src_i,
  output logic [31:0]      irq_o,
  input  logic             irq_ack_i,
  input  logic [4:0]       irq_id_i,
  input  logic             sel_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [1:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [N_SRC-1:0] s1_q, s2_q, s3_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] type_q, type_d;
  logic [N_SRC-1:0] rise, active, ack_hit, w1c, wmask, wdata;
  logic             wr_en;
  logic             claim_valid;
  logic [4:0]       claim_id;
  logic             unused_bus_bits;

  // Only the low N_SRC data bits and their byte lanes matter.
  assign unused_bus_bits = ^{be_i, wdata_i};

  assign wr_en  = sel_i & we_i;
  assign rise   = s2_q & ~s3_q;
  assign active = pending_q & enable_q;
  assign wdata  = wdata_i[N_SRC-1:0];

  always_comb begin
    wmask     = '0;
    ack_hit   = '0;
    w1c       = '0;
    pending_d = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      wmask[k]   = be_i[k/8];
      ack_hit[k] = irq_ack_i && (irq_id_i == 5'(16 + k));
      w1c[k]     = wr_en && (addr_i == 2'd0) && be_i[k/8] && wdata_i[k];
      // Edge: a new rise beats any clear in the same cycle. Level: follow the input.
      if (type_q[k]) begin
        pending_d[k] = rise[k] | (pending_q[k] & ~(ack_hit[k] | w1c[k]));
      end else begin
        pending_d[k] = s2_q[k];
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    type_d   = type_q;
    if (wr_en && (addr_i == 2'd1)) begin
      enable_d = (enable_q & ~wmask) | (wdata & wmask);
    end
    if (wr_en && (addr_i == 2'd2)) begin
      type_d = (type_q & ~wmask) | (wdata & wmask);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      type_q    <= '0;
    end else begin
      s1_q      <= src_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      type_q    <= type_d;
    end
  end

  // Highest active source wins, matching the core's own arbitration.
  always_comb begin
    claim_valid = 1'b0;
    claim_id    = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (active[k]) begin
        claim_valid = 1'b1;
        claim_id    = 5'(16 + k);
      end
    end
  end

  always_comb begin
    irq_o              = '0;
    irq_o[16 +: N_SRC] = active;
  end

  always_comb begin
    rdata_o = '0;
    if (sel_i && !we_i) begin
      unique case (addr_i)
        2'd0: rdata_o[N_SRC-1:0] = pending_q;
        2'd1: rdata_o[N_SRC-1:0] = enable_q;
        2'd2: rdata_o[N_SRC-1:0] = type_q;
        2'd3: rdata_o = {claim_valid, 26'b0, claim_id};
        default: rdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ustcy_irq_ctrl.sv
// Scoreboard bench for ustcy_irq_ctrl: a sample-history reference model predicts irq_o/rdata_o
// each cycle; a negedge monitor compares. Directed scenarios plus a randomized phase.
module tb_ustcy_irq_ctrl;
  localparam int unsigned N = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  src;
  logic [31:0]   irq;
  logic          ack;
  logic [4:0]    id;
  logic          sel, we;
  logic [3:0]    be;
  logic [1:0]    addr;
  logic [31:0]   wdata, rdata;

  ustcy_irq_ctrl #(.N_SRC(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src), .irq_o(irq), .irq_ack_i(ack), .irq_id_i(id),
    .sel_i(sel), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] src;
    logic        ack;
    logic [4:0]  id;
    logic        sel;
    logic        we;
    logic [3:0]  be;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } in_t;

  typedef struct packed {
    logic [31:0] irq;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference state; hist[i] = src_i value sampled i+1 edges ago.
  logic [15:0] m_pend, m_en, m_type;
  logic [15:0] hist [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_pend = '0; m_en = '0; m_type = '0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] c;
    case (a)
      2'd0: return {16'h0, m_pend};
      2'd1: return {16'h0, m_en};
      2'd2: return {16'h0, m_type};
      default: begin
        c = 32'h0;
        for (int k = 0; k < N; k++)
          if (m_pend[k] && m_en[k]) c = 32'h8000_0000 | 32'(16 + k);
        return c;
      end
    endcase
  endfunction

  function automatic void model_edge(input in_t v);
    logic [15:0] m, np;
    logic        clr;
    for (int k = 0; k < N; k++) m[k] = v.be[k/8];
    for (int k = 0; k < N; k++) begin
      if (m_type[k]) begin
        clr = (v.ack && v.id == 5'(16 + k)) ||
              (v.sel && v.we && v.addr == 2'd0 && m[k] && v.wdata[k]);
        if (hist[1][k] && !hist[2][k]) np[k] = 1'b1;
        else if (clr)                  np[k] = 1'b0;
        else                           np[k] = m_pend[k];
      end else begin
        np[k] = hist[1][k];
      end
    end
    if (v.sel && v.we && v.addr == 2'd1) m_en   = (m_en & ~m)   | (v.wdata[15:0] & m);
    if (v.sel && v.we && v.addr == 2'd2) m_type = (m_type & ~m) | (v.wdata[15:0] & m);
    m_pend  = np;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = v.src;
  endfunction

  // Drive one cycle of inputs, queue the predicted outputs, advance the model at the edge.
  task automatic tick(input in_t v);
    exp_t e;
    src = v.src; ack = v.ack; id = v.id; sel = v.sel; we = v.we;
    be = v.be; addr = v.addr; wdata = v.wdata;
    e.irq   = {m_pend & m_en, 16'h0};
    e.rdata = (v.sel && !v.we) ? model_read(v.addr) : 32'h0;
    sbq.push_back(e);
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  task automatic peek(input string name, input logic [1:0] a, input logic [31:0] exp);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    check(name, rdata, exp);
    sel = 1'b0;
  endtask

  function automatic in_t mk(input logic [15:0] s);
    in_t v;
    v = '0;
    v.src = s;
    return v;
  endfunction

  function automatic in_t wr(input logic [15:0] s, input logic [1:0] a, input logic [31:0] d,
                             input logic [3:0] b);
    in_t v;
    v = mk(s);
    v.sel = 1'b1; v.we = 1'b1; v.addr = a; v.wdata = d; v.be = b;
    return v;
  endfunction

  function automatic in_t ak(input logic [15:0] s, input logic [4:0] i);
    in_t v;
    v = mk(s);
    v.ack = 1'b1; v.id = i;
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("irq_o", irq, e.irq);
      check("rdata_o", rdata, e.rdata);
    end
  end

  initial begin
    in_t         v;
    logic [15:0] src_r;

    rst_n = 1'b0; src = '0; ack = 1'b0; id = '0; sel = 1'b0; we = 1'b0;
    be = '0; addr = '0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Edge source 0: visible after the third edge, retired by ack 16.
    tick(wr(16'h0, 2'd2, 32'h1, 4'hF));
    tick(wr(16'h0, 2'd1, 32'h1, 4'hF));
    tick(mk(16'h1));
    tick(mk(16'h0));
    check("edge_lat2", irq, 32'h0);
    tick(mk(16'h0));
    check("edge_lat3", irq, 32'h0001_0000);
    tick(ak(16'h0, 5'd16));
    check("edge_ack", irq, 32'h0);

    // Set beats clear: src 2 rises in the same cycle it is acked.
    tick(wr(16'h0, 2'd2, 32'h5, 4'hF));
    tick(wr(16'h0, 2'd1, 32'h4, 4'hF));
    tick(mk(16'h4));
    tick(mk(16'h0));
    tick(mk(16'h0));
    check("setclr_pend", irq, 32'h0004_0000);
    tick(mk(16'h4));
    tick(mk(16'h4));
    tick(ak(16'h4, 5'd18));
    check("setclr_win", irq, 32'h0004_0000);
    tick(ak(16'h4, 5'd18));
    check("setclr_ack", irq, 32'h0);
    repeat (3) tick(mk(16'h0));

    // Level source 3 ignores ack and W1C, drops three edges after the input falls.
    tick(wr(16'h0, 2'd2, 32'h0, 4'hF));
    tick(wr(16'h0, 2'd1, 32'h8, 4'hF));
    repeat (3) tick(mk(16'h8));
    check("level_on", irq, 32'h0008_0000);
    v = ak(16'h8, 5'd19);
    v.sel = 1'b1; v.we = 1'b1; v.addr = 2'd0; v.wdata = 32'h8; v.be = 4'hF;
    tick(v);
    check("level_ackw1c", irq, 32'h0008_0000);
    tick(mk(16'h0));
    tick(mk(16'h0));
    check("level_hold", irq, 32'h0008_0000);
    tick(mk(16'h0));
    check("level_off", irq, 32'h0);

    // Claim follows the highest enabled pending source.
    tick(wr(16'h0, 2'd2, 32'h22, 4'hF));
    tick(wr(16'h0, 2'd1, 32'h2, 4'hF));
    tick(mk(16'h22));
    tick(mk(16'h0));
    tick(mk(16'h0));
    peek("claim_1", 2'd3, 32'h8000_0011);
    tick(wr(16'h0, 2'd1, 32'h22, 4'hF));
    peek("claim_5", 2'd3, 32'h8000_0015);
    tick(wr(16'h0, 2'd1, 32'h0, 4'hF));
    peek("claim_none", 2'd3, 32'h0);

    // Byte lanes and out-of-range / idle ack ids.
    tick(wr(16'h0, 2'd1, 32'hFFFF, 4'b0001));
    peek("enable_be", 2'd1, 32'h00FF);
    tick(ak(16'h0, 5'd5));
    tick(ak(16'h0, 5'd31));
    peek("ack_ignored", 2'd0, 32'h0022);

    // Asynchronous reset mid-operation with every source held high.
    check("pre_reset_irq", irq, 32'h0022_0000);
    rst_n = 1'b0; src = '1;
    #1;
    check("reset_irq", irq, 32'h0);
    for (int a = 0; a < 4; a++) peek("reset_read", 2'(a), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    tick(mk(16'hFFFF));
    tick(mk(16'hFFFF));
    peek("rerelease_lat2", 2'd0, 32'h0);
    tick(mk(16'hFFFF));
    peek("rerelease_level", 2'd0, 32'h0000_FFFF);

    // Randomized traffic.
    src_r = 16'hFFFF;
    for (int i = 0; i < 1500; i++) begin
      src_r = src_r ^ 16'($urandom & $urandom & $urandom);
      v = mk(src_r);
      v.ack   = ($urandom_range(0, 3) == 0);
      v.id    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                            : 5'($urandom_range(16, 31));
      v.sel   = $urandom_range(0, 1) == 1;
      v.we    = $urandom_range(0, 1) == 1;
      v.addr  = 2'($urandom_range(0, 3));
      v.be    = 4'($urandom);
      v.wdata = $urandom;
      if (v.addr == 2'd0) v.wdata = v.wdata & $urandom & $urandom;
      tick(v);
    end
    tick(mk(16'h0));
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
